// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time instruction memory writer. Takes a framed byte stream
//   (LEN_LO, LEN_HI, 4*N data bytes, CSUM) and packs the data bytes
//   little-endian into 32-bit words. Each completed word is written with a
//   one-cycle strobe. The core is held in reset until a load finishes with a
//   matching XOR checksum.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-low reset
//   start      one-cycle pulse that begins a load (honoured in IDLE/DONE/ERR)
//   rx_valid   byte present on rx_data
//   rx_data    stream byte
//   rx_ready   loader accepts a byte this cycle
//   mem_we     one-cycle write strobe to instruction memory
//   mem_addr   write byte address (word aligned), holds when mem_we=0
//   mem_wdata  write data word, holds when mem_we=0
//   cpu_rst    active-low reset to the core
//   busy       load in progress
//   done       sticky: last load succeeded
//   err        sticky: last load failed
//   dbg_state  current FSM state encoding
//
// Handshake: a byte transfers on a rising clk edge exactly when
//   rx_valid & rx_ready are both high. rx_ready depends only on the FSM state,
//   never on rx_valid, and the source may drop rx_valid for any number of
//   cycles; nothing advances while no byte transfers.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int          DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter bit          AUTO_RELEASE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);

    localparam int WIW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      len;
    logic [WIW-1:0]   word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      asm_buf;   // first three bytes of the word being assembled
    logic [7:0]       csum;

    logic             in_frame;
    logic             accept;
    logic             start_ok;
    logic [15:0]      n_full;
    logic             len_bad;
    logic             last_word;
    logic             csum_ok;

    always_comb begin
        in_frame  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_DATA)   || (state == S_CSUM);
        accept    = rx_valid & in_frame;
        start_ok  = start & ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
        // Full word count as it will be once LEN_HI is latched.
        n_full    = {rx_data, len[7:0]};
        len_bad   = (n_full == 16'd0) || (int'(n_full) > DEPTH);
        last_word = (16'(word_idx) == (len - 16'd1));
        csum_ok   = (rx_data == csum);
    end

    assign rx_ready  = in_frame;
    assign busy      = in_frame;
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) state_nxt = len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (accept && (byte_idx == 2'd3) && last_word) state_nxt = S_CSUM;
            end
            S_CSUM: begin
                if (accept) state_nxt = csum_ok ? S_DONE : S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len       <= 16'd0;
            word_idx  <= '0;
            byte_idx  <= 2'd0;
            asm_buf   <= 24'd0;
            csum      <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'd0;
            cpu_rst   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            if (start_ok) begin
                done     <= 1'b0;
                err      <= 1'b0;
                cpu_rst  <= 1'b0;
                word_idx <= '0;
                byte_idx <= 2'd0;
                csum     <= 8'd0;
            end

            if (accept) begin
                // The checksum byte itself is not folded into the running XOR.
                if (state != S_CSUM) csum <= csum ^ rx_data;

                unique case (state)
                    S_LEN_LO: len[7:0] <= rx_data;
                    S_LEN_HI: begin
                        len[15:8] <= rx_data;
                        if (len_bad) err <= 1'b1;
                    end
                    S_DATA: begin
                        if (byte_idx == 2'd3) begin
                            // Write port registers are loaded from the assembly
                            // buffer, leaving the buffer free for the next word.
                            mem_we    <= 1'b1;
                            mem_addr  <= BASE_ADDR + (32'(word_idx) << 2);
                            mem_wdata <= {rx_data, asm_buf};
                            word_idx  <= word_idx + 1'b1;
                            byte_idx  <= 2'd0;
                        end else begin
                            unique case (byte_idx)
                                2'd0:    asm_buf[7:0]   <= rx_data;
                                2'd1:    asm_buf[15:8]  <= rx_data;
                                default: asm_buf[23:16] <= rx_data;
                            endcase
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                    S_CSUM: begin
                        if (csum_ok) begin
                            done    <= 1'b1;
                            cpu_rst <= AUTO_RELEASE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
